nand_op_sequencer: RTL and testbench
====================================

NAND_OP_SEQUENCER -- requirements
Module: nand_op_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result bit width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port op, input, 2 bits: operation select; 00 NOT a, 01 AND, 10 OR, 11 XOR.
REQ-006 The block SHALL have port a, input, WIDTH bits: first operand.
REQ-007 The block SHALL have port b, input, WIDTH bits: second operand; ignored for NOT.
REQ-008 The block SHALL have port result, output, WIDTH bits: last completed result.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-011 All logic operations SHALL be computed by one shared WIDTH-bit bitwise NAND stage, used at most once per clock; no other logic operator on data.
REQ-012 The block SHALL have states IDLE and STEP, with a 2-bit step index k and per-op step total K: NOT 1, AND 2, OR 3, XOR 4.
REQ-013 In IDLE with busy=0, start=1 at a rising edge SHALL capture a, b and op into internal registers, set busy=1, enter STEP with k=0.
REQ-014 Each STEP cycle SHALL apply one NAND and write its output to a temporary register t0, t1 or t2, or to result on the final step.
REQ-015 The NOT sequence SHALL be: result=nand(a,a).
REQ-016 The AND sequence SHALL be: t0=nand(a,b); result=nand(t0,t0).
REQ-017 The OR sequence SHALL be: t0=nand(a,a); t1=nand(b,b); result=nand(t0,t1).
REQ-018 The XOR sequence SHALL be: t0=nand(a,b); t1=nand(a,t0); t2=nand(b,t0); result=nand(t1,t2).
REQ-019 Latency SHALL be exactly K cycles from the accept edge to the edge writing result; busy SHALL be high for exactly K cycles.
REQ-020 At the final-step edge the block SHALL update result, set done=1 and busy=0, and return to IDLE.
REQ-021 done SHALL be high for exactly one cycle, the cycle after the final-step edge, and low otherwise.
REQ-022 start while busy=1 SHALL be ignored, with no effect on captured operands, op, step index or result.
REQ-023 start=1 in the cycle done=1 SHALL be accepted, because busy=0, giving back-to-back operations with no idle gap.
REQ-024 Changes on a, b or op while busy SHALL NOT affect the in-flight operation.
REQ-025 result SHALL hold its value between completions and change only at a final-step edge or on reset.
REQ-026 start held high continuously SHALL launch a new operation each time busy falls, re-sampling a, b and op.

Reset
REQ-027 reset=1 at a rising edge SHALL set result=0, busy=0, done=0, step index 0, temporaries 0, and state IDLE.
REQ-028 reset SHALL take priority over start and over an in-flight step.
REQ-029 An operation interrupted by reset SHALL be abandoned with no done pulse and no result update.
REQ-030 start asserted while reset=1 SHALL be ignored; the first accept SHALL occur at the first edge with reset=0.

Verification
REQ-031 Bench SHALL check: a=0x00FF, op=00, start for 1 cycle -> busy for 1 cycle, then done=1 and result=0xFF00.
REQ-032 Bench SHALL check: a=0x00FF, b=0x0F0F run with AND, OR and XOR back-to-back using start in each done cycle -> results 0x000F, 0x0FFF, 0x0FF0 after latencies 2, 3 and 4; no idle cycle between operations.
REQ-033 Bench SHALL check: XOR accepted with a=0xAAAA, b=0xFFFF, then a=0x0000, b=0x0000, op=00 and start=1 driven during busy -> result=0x5555 after 4 cycles; the start pulses are ignored.
REQ-034 Bench SHALL check: OR accepted, reset asserted on its second busy cycle -> result=0x0000, busy=0, and done never pulses.
REQ-035 Bench SHALL check: start and reset both high for 1 cycle, then reset=0 with start=1 and AND with a=0xFFFF, b=0x1234 -> nothing accepted during reset; next edge accepts; result=0x1234 after 2 cycles.
REQ-036 Bench SHALL check: for all 4 ops and 1000 random operand pairs -> result matches the bitwise reference, done is exactly one cycle per op, and latency is 1, 2, 3 or 4 respectively.

Source files
------------

// File: rtl/nand_op_if.sv
// nand_op_if: bundles the request/response signals of nand_op_sequencer.
//   start  - request to begin an operation (master -> slave)
//   op     - operation select: 00 NOT a, 01 AND, 10 OR, 11 XOR
//   a, b   - operands, WIDTH bits each (b unused for NOT)
//   result - last completed result (slave -> master)
//   busy   - high while an operation is in progress
//   done   - one-cycle completion pulse
interface nand_op_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b,
        input  result, busy, done
    );

    modport slave (
        input  start, op, a, b,
        output result, busy, done
    );
endinterface

// File: rtl/nand_op_sequencer.sv
// nand_op_sequencer: evaluates NOT/AND/OR/XOR on WIDTH-bit operands using a
// single shared bitwise NAND stage, one NAND per clock. Each operation takes
// op+1 cycles (NOT 1, AND 2, OR 3, XOR 4).
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous active-high reset
//   bus   - nand_op_if.slave: start/op/a/b in, result/busy/done out
module nand_op_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic      clk,
    input  logic      reset,
    nand_op_if.slave  bus
);

    typedef enum logic {
        IDLE,
        STEP
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [1:0]       step_k;
    logic [WIDTH-1:0] t0;
    logic [WIDTH-1:0] t1;
    logic [WIDTH-1:0] t2;
    logic [WIDTH-1:0] result_q;
    logic             done_q;

    logic [WIDTH-1:0] nand_x;
    logic [WIDTH-1:0] nand_y;
    logic [WIDTH-1:0] nand_out;
    logic             final_step;

    // The op encoding equals its step total minus one, so the final step is
    // reached when the step index matches the captured op.
    assign final_step = (step_k == op_q);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept only from IDLE, leave STEP after the final NAND.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.start) state_next = STEP;
            STEP: if (final_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: busy is purely the STEP state; done and result are registers.
    always_comb begin
        bus.busy   = (state == STEP);
        bus.done   = done_q;
        bus.result = result_q;
    end

    // Operand routing into the shared NAND stage for each op and step.
    always_comb begin
        nand_x = '0;
        nand_y = '0;
        case (op_q)
            2'd0: begin
                nand_x = a_q;
                nand_y = a_q;
            end
            2'd1: begin
                if (step_k == 2'd0) begin
                    nand_x = a_q;
                    nand_y = b_q;
                end else begin
                    nand_x = t0;
                    nand_y = t0;
                end
            end
            2'd2: begin
                case (step_k)
                    2'd0: begin
                        nand_x = a_q;
                        nand_y = a_q;
                    end
                    2'd1: begin
                        nand_x = b_q;
                        nand_y = b_q;
                    end
                    default: begin
                        nand_x = t0;
                        nand_y = t1;
                    end
                endcase
            end
            default: begin
                case (step_k)
                    2'd0: begin
                        nand_x = a_q;
                        nand_y = b_q;
                    end
                    2'd1: begin
                        nand_x = a_q;
                        nand_y = t0;
                    end
                    2'd2: begin
                        nand_x = b_q;
                        nand_y = t0;
                    end
                    default: begin
                        nand_x = t1;
                        nand_y = t2;
                    end
                endcase
            end
        endcase
    end

    assign nand_out = ~(nand_x & nand_y);

    // Datapath: capture on accept, then one NAND per cycle. Intermediate step k
    // always lands in temporary t<k>; the final step writes result and pulses done.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 2'd0;
            step_k   <= 2'd0;
            t0       <= '0;
            t1       <= '0;
            t2       <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    a_q    <= bus.a;
                    b_q    <= bus.b;
                    op_q   <= bus.op;
                    step_k <= 2'd0;
                end
            end else begin
                if (final_step) begin
                    result_q <= nand_out;
                    done_q   <= 1'b1;
                    step_k   <= 2'd0;
                end else begin
                    case (step_k)
                        2'd0:    t0 <= nand_out;
                        2'd1:    t1 <= nand_out;
                        default: t2 <= nand_out;
                    endcase
                    step_k <= 2'(step_k + 2'd1);
                end
            end
        end
    end

endmodule

// File: tb/tb_nand_op_sequencer.sv
// tb_nand_op_sequencer: self-checking bench for nand_op_sequencer. Directed
// vector table, hand-written multi-cycle sequences (back-to-back, start while
// busy, reset mid-operation, start during reset) and a randomized run compared
// against a plain bitwise reference.
module tb_nand_op_sequencer;

    localparam int WIDTH = 16;

    logic clk;
    logic reset;

    nand_op_if #(.WIDTH(WIDTH)) bus ();

    nand_op_sequencer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    int errors = 0;
    int checks = 0;

    logic [1:0]  rop;
    logic [15:0] ra;
    logic [15:0] rb;
    int          done_seen;

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit in case something stalls outside the bounded loops.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: what each op means, independent of how it is sequenced.
    function automatic logic [15:0] refModel(input logic [1:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
        case (op)
            2'd0:    return ~a;
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present an operation with a one-cycle start pulse and confirm acceptance.
    task automatic applyStimulus(input string name, input logic [1:0] op,
                                 input logic [15:0] a, input logic [15:0] b);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checkOutput({name, "_accept_busy"}, 32'(bus.busy), 32'd1);
        checkOutput({name, "_accept_done"}, 32'(bus.done), 32'd0);
    endtask

    // Called in the cycle after the accept edge; returns in the done cycle.
    // Latency is counted in edges from the accept edge to the result edge.
    task automatic waitDone(input string name, input logic [15:0] exp_res,
                            input int exp_lat, input bit scramble);
        int lat;
        int bcnt;
        lat  = 0;
        bcnt = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.busy === 1'b1) bcnt++;
            tick();
            lat++;
            if (scramble) begin
                bus.a  = 16'($urandom);
                bus.b  = 16'($urandom);
                bus.op = 2'($urandom_range(0, 3));
            end
        end
        checkOutput({name, "_done_seen"}, 32'(bus.done), 32'd1);
        checkOutput({name, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({name, "_busy_cycles"}, 32'(bcnt), 32'(exp_lat));
        checkOutput({name, "_result"}, 32'(bus.result), 32'(exp_res));
        checkOutput({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{"not_00ff",  2'd0, 16'h00FF, 16'h0000, 16'hFF00, 1};
        vecs[1] = '{"and_basic", 2'd1, 16'h00FF, 16'h0F0F, 16'h000F, 2};
        vecs[2] = '{"or_basic",  2'd2, 16'h00FF, 16'h0F0F, 16'h0FFF, 3};
        vecs[3] = '{"xor_basic", 2'd3, 16'h00FF, 16'h0F0F, 16'h0FF0, 4};
        vecs[4] = '{"not_zero",  2'd0, 16'h0000, 16'h1234, 16'hFFFF, 1};
        vecs[5] = '{"xor_same",  2'd3, 16'hFFFF, 16'hFFFF, 16'h0000, 4};
        vecs[6] = '{"and_mask",  2'd1, 16'hFFFF, 16'h1234, 16'h1234, 2};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        checkOutput("reset_result", 32'(bus.result), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        tick();

        $display("[TB] directed vector table");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b);
            waitDone(vecs[i].name, vecs[i].res, vecs[i].lat, 1'b0);
            tick();
            checkOutput({vecs[i].name, "_done_one_cycle"}, 32'(bus.done), 32'd0);
            checkOutput({vecs[i].name, "_result_hold"}, 32'(bus.result), 32'(vecs[i].res));
        end

        $display("[TB] back-to-back AND, OR, XOR");
        applyStimulus("b2b_and", 2'd1, 16'h00FF, 16'h0F0F);
        waitDone("b2b_and", 16'h000F, 2, 1'b0);
        applyStimulus("b2b_or", 2'd2, 16'h00FF, 16'h0F0F);
        waitDone("b2b_or", 16'h0FFF, 3, 1'b0);
        applyStimulus("b2b_xor", 2'd3, 16'h00FF, 16'h0F0F);
        waitDone("b2b_xor", 16'h0FF0, 4, 1'b0);
        tick();
        checkOutput("b2b_done_one_cycle", 32'(bus.done), 32'd0);

        $display("[TB] start and new inputs while busy");
        applyStimulus("busy_xor", 2'd3, 16'hAAAA, 16'hFFFF);
        bus.a     = 16'h0000;
        bus.b     = 16'h0000;
        bus.op    = 2'd0;
        bus.start = 1'b1;
        waitDone("busy_xor", 16'h5555, 4, 1'b0);
        bus.start = 1'b0;
        tick();
        checkOutput("busy_xor_no_relaunch", 32'(bus.busy), 32'd0);
        checkOutput("busy_xor_done_low", 32'(bus.done), 32'd0);
        checkOutput("busy_xor_result_hold", 32'(bus.result), 32'h5555);

        $display("[TB] reset during OR");
        applyStimulus("rst_or", 2'd2, 16'h1234, 16'h4321);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst_or_result", 32'(bus.result), 32'd0);
        checkOutput("rst_or_busy", 32'(bus.busy), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done === 1'b1) done_seen++;
            tick();
        end
        checkOutput("rst_or_no_done", 32'(done_seen), 32'd0);
        checkOutput("rst_or_result_after", 32'(bus.result), 32'd0);

        $display("[TB] start during reset");
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.op    = 2'd1;
        bus.a     = 16'hFFFF;
        bus.b     = 16'h1234;
        tick();
        checkOutput("rst_start_ignored", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        tick();
        bus.start = 1'b0;
        checkOutput("rst_start_accept", 32'(bus.busy), 32'd1);
        waitDone("rst_start_and", 16'h1234, 2, 1'b0);
        tick();

        $display("[TB] randomized operations");
        for (int i = 0; i < 1000; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            applyStimulus("rand", rop, ra, rb);
            waitDone("rand", refModel(rop, ra, rb), int'(rop) + 1, 1'b1);
            if ($urandom_range(0, 1) == 0) begin
                tick();
                checkOutput("rand_done_one_cycle", 32'(bus.done), 32'd0);
                checkOutput("rand_idle_busy", 32'(bus.busy), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
